// File: rtl/perc_seq_if.sv
// Bus bundle between the perceptron command sequencer and its UART,
// accumulator and byte-mux neighbours. The master side is the sequencer.
interface perc_seq_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_busy;
  logic [7:0] mux_data;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [3:0] sel;
  logic       acc_add;
  logic       acc_clear;
  logic [7:0] status;
  logic       busy;

  modport master (
    input  rx_data, rx_valid, tx_busy, mux_data,
    output tx_start, tx_data, sel, acc_add, acc_clear, status, busy
  );

  modport slave (
    output rx_data, rx_valid, tx_busy, mux_data,
    input  tx_start, tx_data, sel, acc_add, acc_clear, status, busy
  );
endinterface

// File: rtl/perc_seq.sv
// Command sequencer for the perceptron datapath. Decodes UART command bytes
// {op, n}, strobes the accumulator add/clear inputs, walks the accumulator
// byte select to stream results out through the UART under its busy
// handshake, and keeps a {busy, last_op, err_cnt} status byte for the LEDs.
module perc_seq #(
  parameter int ADD_GAP = 4  // cycles between acc_add pulses, 1..15
) (
  input  logic        clk,
  input  logic        Rst,
  perc_seq_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLR      = 3'd1,
    ADD      = 3'd2,
    GAP      = 3'd3,
    TX_START = 3'd4,
    TX_HOLD  = 3'd5,
    TX_WAIT  = 3'd6
  } state_t;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_CLEAR  = 4'h1;
  localparam logic [3:0] OP_ACC    = 4'h2;
  localparam logic [3:0] OP_READ   = 4'h3;
  localparam logic [3:0] OP_STATUS = 4'h4;

  // GAP is occupied for ADD_GAP-1 cycles; gap_reg counts 0..GAP_LAST there.
  // With ADD_GAP=1 the GAP state is never entered and this value is unused.
  localparam logic [3:0] GAP_LAST = (ADD_GAP > 1) ? 4'(ADD_GAP - 2) : 4'd0;
  localparam bit         GAP_NONE = (ADD_GAP <= 1);

  state_t     state_reg, state_next;
  logic [3:0] n_reg, n_next;              // index of the final pulse/byte
  logic [3:0] cnt_reg, cnt_next;          // index of the current add pulse
  logic [3:0] gap_reg, gap_next;          // cycles spent in GAP so far
  logic [3:0] sel_reg, sel_next;          // accumulator byte being sent
  logic       stat_mode_reg, stat_mode_next;
  logic [7:0] stat_latch_reg, stat_latch_next;
  logic [2:0] last_op_reg, last_op_next;
  logic [3:0] err_reg, err_next;
  logic       err_inc;

  logic [3:0] rx_op;
  logic [3:0] rx_n;

  assign rx_op = bus.rx_data[7:4];
  assign rx_n  = bus.rx_data[3:0];

  // Next-state and datapath update; every strobe is a pure state decode.
  always_comb begin
    state_next      = state_reg;
    n_next          = n_reg;
    cnt_next        = cnt_reg;
    gap_next        = gap_reg;
    sel_next        = sel_reg;
    stat_mode_next  = stat_mode_reg;
    stat_latch_next = stat_latch_reg;
    last_op_next    = last_op_reg;
    err_next        = err_reg;
    err_inc         = 1'b0;

    case (state_reg)
      IDLE: begin
        sel_next = 4'd0;
        if (bus.rx_valid) begin
          if (rx_op > OP_STATUS) begin
            err_inc = 1'b1;
          end else begin
            last_op_next = rx_op[2:0];
            n_next       = rx_n;
            cnt_next     = 4'd0;
            gap_next     = 4'd0;
            case (rx_op)
              OP_NOP:   state_next = IDLE;
              OP_CLEAR: state_next = CLR;
              OP_ACC:   state_next = ADD;
              OP_READ: begin
                state_next     = TX_START;
                stat_mode_next = 1'b0;
              end
              OP_STATUS: begin
                // One byte only; the reported busy bit reflects this
                // STATUS command being in progress, last_op the previous one.
                state_next      = TX_START;
                stat_mode_next  = 1'b1;
                n_next          = 4'd0;
                stat_latch_next = {1'b1, last_op_reg, err_reg};
              end
              default: state_next = IDLE;
            endcase
          end
        end
      end

      CLR: state_next = IDLE;

      ADD: begin
        if (cnt_reg == n_reg) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 4'd1;
          gap_next = 4'd0;
          state_next = GAP_NONE ? ADD : GAP;
        end
      end

      GAP: begin
        if (gap_reg == GAP_LAST) begin
          state_next = ADD;
        end else begin
          gap_next = gap_reg + 4'd1;
        end
      end

      TX_START: state_next = TX_HOLD;

      // The UART raises busy one cycle after tx_start, so it is not
      // looked at until TX_WAIT.
      TX_HOLD: state_next = TX_WAIT;

      TX_WAIT: begin
        if (!bus.tx_busy) begin
          if (sel_reg == n_reg) begin
            state_next = IDLE;
            sel_next   = 4'd0;
          end else begin
            state_next = TX_START;
            sel_next   = sel_reg + 4'd1;
          end
        end
      end

      default: begin
        state_next = IDLE;
        sel_next   = 4'd0;
      end
    endcase

    // A byte arriving while busy (including the cycle of return to IDLE)
    // is an overrun and is dropped.
    if (bus.rx_valid && (state_reg != IDLE)) begin
      err_inc = 1'b1;
    end

    if (err_inc && (err_reg != 4'hF)) begin
      err_next = err_reg + 4'd1;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_reg      <= IDLE;
      n_reg          <= 4'd0;
      cnt_reg        <= 4'd0;
      gap_reg        <= 4'd0;
      sel_reg        <= 4'd0;
      stat_mode_reg  <= 1'b0;
      stat_latch_reg <= 8'h00;
      last_op_reg    <= 3'd0;
      err_reg        <= 4'd0;
    end else begin
      state_reg      <= state_next;
      n_reg          <= n_next;
      cnt_reg        <= cnt_next;
      gap_reg        <= gap_next;
      sel_reg        <= sel_next;
      stat_mode_reg  <= stat_mode_next;
      stat_latch_reg <= stat_latch_next;
      last_op_reg    <= last_op_next;
      err_reg        <= err_next;
    end
  end

  assign bus.acc_clear = (state_reg == CLR);
  assign bus.acc_add   = (state_reg == ADD);
  assign bus.tx_start  = (state_reg == TX_START);
  assign bus.busy      = (state_reg != IDLE);
  assign bus.sel       = sel_reg;
  assign bus.status    = {bus.busy, last_op_reg, err_reg};
  assign bus.tx_data   = stat_mode_reg ? stat_latch_reg : bus.mux_data;

endmodule

// File: tb/tb_perc_seq.sv
// Self-checking bench for perc_seq: directed scenarios plus a randomized
// command stream, all checked against a timeline model built from the
// command rules (pulse times, byte times, error counting).
module tb_perc_seq;
  localparam int GAP = 4;

  logic clk = 1'b0;
  logic Rst = 1'b1;
  always #5 clk = ~clk;

  perc_seq_if bus ();

  perc_seq #(.ADD_GAP(GAP)) dut (
    .clk (clk),
    .Rst (Rst),
    .bus (bus)
  );

  int cyc = 0;
  int busy_len = 10;
  int ucnt = 0;
  logic [7:0] mux_mem [16];

  int n_cmp = 0;
  int n_mis = 0;

  int         add_q[$], clr_q[$], txc_q[$];
  logic [7:0] txd_q[$];
  int         exp_add_q[$], exp_clr_q[$], exp_txc_q[$];
  logic [7:0] exp_txd_q[$];
  int         overlap_cnt = 0;
  int         sel_bad = 0;
  logic [3:0] prev_sel = 4'd0;

  int m_err = 0;
  int m_last_op = 0;
  int m_idle_at = 0;

  // Cycle counter: value k between posedge k and posedge k+1.
  always @(posedge clk) cyc <= cyc + 1;

  // Stub UART transmitter: busy rises the cycle after tx_start.
  always @(posedge clk) begin
    if (Rst) ucnt <= 0;
    else if (bus.tx_start) ucnt <= busy_len;
    else if (ucnt != 0) ucnt <= ucnt - 1;
  end
  assign bus.tx_busy  = (ucnt != 0);
  assign bus.mux_data = mux_mem[bus.sel];

  // Event monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (!Rst) begin
      if (bus.acc_add) add_q.push_back(cyc);
      if (bus.acc_clear) clr_q.push_back(cyc);
      if (bus.tx_start) begin
        txc_q.push_back(cyc);
        txd_q.push_back(bus.tx_data);
      end
      if (int'(bus.acc_add) + int'(bus.acc_clear) + int'(bus.tx_start) > 1)
        overlap_cnt <= overlap_cnt + 1;
      if (bus.tx_busy && (bus.sel != prev_sel)) sel_bad <= sel_bad + 1;
    end
    prev_sel <= bus.sel;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_all();
    add_q.delete(); clr_q.delete(); txc_q.delete(); txd_q.delete();
    exp_add_q.delete(); exp_clr_q.delete(); exp_txc_q.delete(); exp_txd_q.delete();
  endtask

  // Reference model: predicts acceptance, error count and event timeline.
  task automatic model_rx(input logic [7:0] b, input int c);
    int op, n, s, w, last;
    logic [7:0] sb;
    op = int'(b[7:4]);
    n  = int'(b[3:0]);
    if (c < m_idle_at || op >= 5) begin
      if (m_err < 15) m_err++;
      return;
    end
    sb = 8'(128 + m_last_op * 16 + m_err);
    m_last_op = op;
    case (op)
      0: m_idle_at = c + 1;
      1: begin
        exp_clr_q.push_back(c + 1);
        m_idle_at = c + 2;
      end
      2: begin
        for (int k = 0; k <= n; k++) exp_add_q.push_back(c + 1 + k * GAP);
        m_idle_at = c + 2 + n * GAP;
      end
      default: begin
        last = (op == 4) ? 0 : n;
        s = c + 1;
        for (int k = 0; k <= last; k++) begin
          exp_txc_q.push_back(s);
          exp_txd_q.push_back((op == 4) ? sb : mux_mem[k]);
          w = (s + 2 > s + busy_len + 1) ? s + 2 : s + busy_len + 1;
          s = w + 1;
        end
        m_idle_at = s;
      end
    endcase
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    model_rx(b, cyc);
    step();
    bus.rx_valid = 1'b0;
  endtask

  task automatic settle();
    while (cyc < m_idle_at + 2) step();
  endtask

  task automatic model_reset();
    m_err = 0;
    m_last_op = 0;
    m_idle_at = cyc;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    step();
    step();
    n_cmp += 6;
    if (bus.tx_start !== 1'b0) begin n_mis++; $display("FAIL reset_tx_start: got %b want 0", bus.tx_start); end
    if (bus.sel !== 4'd0) begin n_mis++; $display("FAIL reset_sel: got %0d want 0", bus.sel); end
    if (bus.acc_add !== 1'b0) begin n_mis++; $display("FAIL reset_acc_add: got %b want 0", bus.acc_add); end
    if (bus.acc_clear !== 1'b0) begin n_mis++; $display("FAIL reset_acc_clear: got %b want 0", bus.acc_clear); end
    if (bus.busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    if (bus.status !== 8'h00) begin n_mis++; $display("FAIL reset_status: got %h want 00", bus.status); end
    Rst = 1'b0;
    model_reset();
    clr_all();
    $display("reset: status=%h busy=%b", bus.status, bus.busy);
  endtask

  task automatic test_clear();
    int t;
    clr_all();
    t = cyc;
    send(8'h10);
    n_cmp += 2;
    if (bus.acc_clear !== 1'b1) begin n_mis++; $display("FAIL clear_pulse: got %b want 1 at t+1", bus.acc_clear); end
    if (bus.busy !== 1'b1) begin n_mis++; $display("FAIL clear_busy_t1: got %b want 1", bus.busy); end
    step();
    n_cmp += 2;
    if (bus.acc_clear !== 1'b0) begin n_mis++; $display("FAIL clear_width: got %b want 0 at t+2", bus.acc_clear); end
    if (bus.busy !== 1'b0) begin n_mis++; $display("FAIL clear_busy_t2: got %b want 0", bus.busy); end
    settle();
    n_cmp += 3;
    if (clr_q.size() != exp_clr_q.size() || clr_q[0] !== exp_clr_q[0])
      begin n_mis++; $display("FAIL clear_events: got %0d pulses want %0d at %0d", clr_q.size(), exp_clr_q.size(), t + 1); end
    if (add_q.size() + txc_q.size() != 0)
      begin n_mis++; $display("FAIL clear_stray: got %0d other strobes want 0", add_q.size() + txc_q.size()); end
    if (bus.status !== 8'(m_last_op * 16 + m_err))
      begin n_mis++; $display("FAIL clear_status: got %h want %h", bus.status, 8'(m_last_op * 16 + m_err)); end
    $display("clear: t=%0d pulses=%0d status=%h", t, clr_q.size(), bus.status);
  endtask

  task automatic test_acc();
    int t;
    clr_all();
    t = cyc;
    send(8'h22);
    for (int k = 0; k < 12; k++) begin
      n_cmp++;
      if (bus.busy !== (cyc < m_idle_at))
        begin n_mis++; $display("FAIL acc_busy: cycle t+%0d got %b want %b", cyc - t, bus.busy, cyc < m_idle_at); end
      step();
    end
    settle();
    n_cmp++;
    if (add_q.size() != exp_add_q.size())
      begin n_mis++; $display("FAIL acc_count: got %0d want %0d", add_q.size(), exp_add_q.size()); end
    else foreach (exp_add_q[i]) begin
      n_cmp++;
      if (add_q[i] !== exp_add_q[i])
        begin n_mis++; $display("FAIL acc_time: pulse %0d got t+%0d want t+%0d", i, add_q[i] - t, exp_add_q[i] - t); end
    end
    $display("acc: t=%0d pulses=%0d", t, add_q.size());
  endtask

  task automatic test_read();
    clr_all();
    busy_len = 10;
    for (int i = 0; i < 16; i++) mux_mem[i] = 8'(8'hA0 + i);
    send(8'h33);
    settle();
    n_cmp++;
    if (txd_q.size() != exp_txd_q.size())
      begin n_mis++; $display("FAIL read_count: got %0d want %0d", txd_q.size(), exp_txd_q.size()); end
    else foreach (exp_txd_q[i]) begin
      n_cmp += 2;
      if (txd_q[i] !== exp_txd_q[i])
        begin n_mis++; $display("FAIL read_data: byte %0d got %h want %h", i, txd_q[i], exp_txd_q[i]); end
      if (txc_q[i] !== exp_txc_q[i])
        begin n_mis++; $display("FAIL read_time: byte %0d got %0d want %0d", i, txc_q[i], exp_txc_q[i]); end
    end
    n_cmp += 3;
    if (sel_bad !== 0) begin n_mis++; $display("FAIL read_sel_stable: got %0d changes want 0", sel_bad); end
    if (bus.sel !== 4'd0) begin n_mis++; $display("FAIL read_sel_idle: got %0d want 0", bus.sel); end
    if (bus.busy !== 1'b0) begin n_mis++; $display("FAIL read_idle: got busy %b want 0", bus.busy); end
    $display("read: bytes=%0d sel=%0d", txd_q.size(), bus.sel);
  endtask

  task automatic test_errors();
    clr_all();
    busy_len = 3;
    send(8'h7F);
    step();
    send(8'h3F);
    repeat (20) step();
    send(8'h00);
    settle();
    n_cmp++;
    if (txd_q.size() != exp_txd_q.size())
      begin n_mis++; $display("FAIL err_read_count: got %0d want %0d", txd_q.size(), exp_txd_q.size()); end
    else foreach (exp_txd_q[i]) begin
      n_cmp++;
      if (txd_q[i] !== exp_txd_q[i] || txc_q[i] !== exp_txc_q[i])
        begin n_mis++; $display("FAIL err_read_byte: byte %0d got %h@%0d want %h@%0d", i, txd_q[i], txc_q[i], exp_txd_q[i], exp_txc_q[i]); end
    end
    n_cmp += 2;
    if (bus.status !== 8'(m_last_op * 16 + m_err))
      begin n_mis++; $display("FAIL err_status: got %h want %h", bus.status, 8'(m_last_op * 16 + m_err)); end
    if (bus.status[3:0] !== 4'd2)
      begin n_mis++; $display("FAIL err_count: got %0d want 2", bus.status[3:0]); end
    $display("errors: bytes=%0d status=%h", txd_q.size(), bus.status);
  endtask

  task automatic test_status();
    clr_all();
    send(8'h40);
    settle();
    n_cmp += 2;
    if (txd_q.size() != 1 || txd_q[0] !== exp_txd_q[0])
      begin n_mis++; $display("FAIL status_byte: got %0d bytes first %h want 1 byte %h", txd_q.size(), (txd_q.size() > 0) ? txd_q[0] : 8'h00, exp_txd_q[0]); end
    if (exp_txd_q[0] !== 8'hB2 || txd_q.size() == 0 || txd_q[0] !== 8'hB2)
      begin n_mis++; $display("FAIL status_value: got %h want b2", (txd_q.size() > 0) ? txd_q[0] : 8'h00); end
    $display("status: bytes=%0d status=%h", txd_q.size(), bus.status);
  endtask

  task automatic test_saturate();
    clr_all();
    for (int i = 0; i < 17; i++) send(8'($urandom_range(8'h50, 8'hFF)));
    step();
    n_cmp += 2;
    if (bus.status[3:0] !== 4'hF)
      begin n_mis++; $display("FAIL sat_err: got %0d want 15", bus.status[3:0]); end
    if (bus.status !== 8'(m_last_op * 16 + m_err))
      begin n_mis++; $display("FAIL sat_status: got %h want %h", bus.status, 8'(m_last_op * 16 + m_err)); end
    $display("saturate: status=%h", bus.status);
  endtask

  task automatic test_reset_mid_read();
    int lim, s;
    clr_all();
    busy_len = 4;
    send(8'h3F);
    lim = 0;
    while (txc_q.size() < 5 && lim < 500) begin step(); lim++; end
    n_cmp++;
    if (txc_q.size() < 5) begin
      n_mis++; $display("FAIL rmr_reach: got %0d bytes want 5 within budget", txc_q.size());
    end else begin
      s = txc_q[4];
      while (cyc < s + 3) step();
      Rst = 1'b1;
      step();
      n_cmp += 6;
      if (bus.tx_start !== 1'b0) begin n_mis++; $display("FAIL rmr_tx_start: got %b want 0", bus.tx_start); end
      if (bus.sel !== 4'd0) begin n_mis++; $display("FAIL rmr_sel: got %0d want 0", bus.sel); end
      if (bus.acc_add !== 1'b0) begin n_mis++; $display("FAIL rmr_acc_add: got %b want 0", bus.acc_add); end
      if (bus.acc_clear !== 1'b0) begin n_mis++; $display("FAIL rmr_acc_clear: got %b want 0", bus.acc_clear); end
      if (bus.busy !== 1'b0) begin n_mis++; $display("FAIL rmr_busy: got %b want 0", bus.busy); end
      if (bus.status !== 8'h00) begin n_mis++; $display("FAIL rmr_status: got %h want 00", bus.status); end
      Rst = 1'b0;
      model_reset();
      repeat (30) step();
      n_cmp++;
      if (txc_q.size() != 5) begin n_mis++; $display("FAIL rmr_no_more_tx: got %0d bytes want 5", txc_q.size()); end
      for (int i = 0; i < 5 && i < txd_q.size(); i++) begin
        n_cmp++;
        if (txd_q[i] !== mux_mem[i])
          begin n_mis++; $display("FAIL rmr_data: byte %0d got %h want %h", i, txd_q[i], mux_mem[i]); end
      end
    end
    clr_all();
    send(8'h10);
    settle();
    n_cmp += 2;
    if (clr_q.size() != 1 || clr_q[0] !== exp_clr_q[0])
      begin n_mis++; $display("FAIL rmr_new_cmd: got %0d clears want 1", clr_q.size()); end
    if (bus.status !== 8'h10) begin n_mis++; $display("FAIL rmr_new_status: got %h want 10", bus.status); end
    $display("reset_mid_read: bytes_before=%0d status=%h", 5, bus.status);
  endtask

  task automatic test_random();
    int r, op, n, d;
    logic [7:0] b;
    clr_all();
    busy_len = $urandom_range(1, 6);
    for (int i = 0; i < 16; i++) mux_mem[i] = 8'($urandom_range(0, 255));
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      n = $urandom_range(0, 15);
      case (r)
        0: op = 0;
        1: op = 1;
        2, 3: begin op = 2; n = n % 8; end
        4, 5: op = 3;
        6: op = 4;
        default: op = $urandom_range(5, 15);
      endcase
      b = 8'(op * 16 + n);
      if ($urandom_range(0, 3) != 0) begin
        d = $urandom_range(0, 2);
        while (cyc < m_idle_at - 1 + d) step();
      end
      send(b);
      $display("random: cmd %0d byte=%h cycle=%0d err_model=%0d", it, b, cyc - 1, m_err);
    end
    settle();
    n_cmp += 4;
    if (add_q.size() != exp_add_q.size())
      begin n_mis++; $display("FAIL rand_add_count: got %0d want %0d", add_q.size(), exp_add_q.size()); end
    else foreach (exp_add_q[i]) begin
      n_cmp++;
      if (add_q[i] !== exp_add_q[i]) begin n_mis++; $display("FAIL rand_add_time: %0d got %0d want %0d", i, add_q[i], exp_add_q[i]); end
    end
    if (clr_q.size() != exp_clr_q.size())
      begin n_mis++; $display("FAIL rand_clr_count: got %0d want %0d", clr_q.size(), exp_clr_q.size()); end
    else foreach (exp_clr_q[i]) begin
      n_cmp++;
      if (clr_q[i] !== exp_clr_q[i]) begin n_mis++; $display("FAIL rand_clr_time: %0d got %0d want %0d", i, clr_q[i], exp_clr_q[i]); end
    end
    if (txd_q.size() != exp_txd_q.size())
      begin n_mis++; $display("FAIL rand_tx_count: got %0d want %0d", txd_q.size(), exp_txd_q.size()); end
    else foreach (exp_txd_q[i]) begin
      n_cmp++;
      if (txd_q[i] !== exp_txd_q[i] || txc_q[i] !== exp_txc_q[i])
        begin n_mis++; $display("FAIL rand_tx: %0d got %h@%0d want %h@%0d", i, txd_q[i], txc_q[i], exp_txd_q[i], exp_txc_q[i]); end
    end
    if (bus.status !== 8'(m_last_op * 16 + m_err))
      begin n_mis++; $display("FAIL rand_status: got %h want %h", bus.status, 8'(m_last_op * 16 + m_err)); end
    n_cmp += 2;
    if (overlap_cnt !== 0) begin n_mis++; $display("FAIL strobe_overlap: got %0d want 0", overlap_cnt); end
    if (sel_bad !== 0) begin n_mis++; $display("FAIL sel_stable: got %0d changes want 0", sel_bad); end
    $display("random: adds=%0d clears=%0d bytes=%0d status=%h", add_q.size(), clr_q.size(), txd_q.size(), bus.status);
  endtask

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    for (int i = 0; i < 16; i++) mux_mem[i] = 8'(8'hA0 + i);
    test_reset();
    test_clear();
    test_acc();
    test_read();
    test_errors();
    test_status();
    test_saturate();
    test_reset_mid_read();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/perc_seq.md
# perc_seq

Command sequencer for the perceptron datapath. Decodes command bytes arriving from the UART receiver, drives the accumulator's `add`/`clear` strobes, and walks the 4-bit byte select of the 128-bit accumulator mux to stream results back through the UART transmitter under its busy handshake. It also keeps a status/error byte for the LEDs. It replaces ad-hoc control between `uart`, `acc` and `mux` with a single deterministic state machine.

## Interface
- `ADD_GAP`, 4: cycles between successive `acc_add` pulses in an ACC burst; legal range 1..15.
- `clk`  in  1  system clock, all logic on rising edge
- `Rst`  in  1  synchronous, active-high reset
- `rx_data`  in  8  received command byte, valid when `rx_valid`=1
- `rx_valid`  in  1  single-cycle strobe from the UART receiver
- `tx_busy`  in  1  UART transmitter busy
- `mux_data`  in  8  accumulator byte selected by `sel`
- `tx_start`  out  1  single-cycle transmit strobe to the UART
- `tx_data`  out  8  byte to transmit; `mux_data` for READ, status byte for STATUS
- `sel`  out  4  accumulator byte select (0 = least-significant byte)
- `acc_add`  out  1  accumulate strobe
- `acc_clear`  out  1  accumulator clear strobe
- `status`  out  8  {busy, last_op[2:0], err_cnt[3:0]}, drives LEDs
- `busy`  out  1  high whenever state ≠ IDLE

## Operation
- Command byte = {op[3:0], n[3:0]}. Accepted only in IDLE on a cycle with `rx_valid`=1.
  - 0x0n NOP: no action; `last_op` updated.
  - 0x1n CLEAR: one-cycle `acc_clear`.
  - 0x2n ACC: n+1 `acc_add` pulses, spaced `ADD_GAP` cycles.
  - 0x3n READ: transmit accumulator bytes `sel`=0..n, LSB first, n+1 bytes.
  - 0x4n STATUS: transmit one byte equal to the `status` value latched at accept.
  - op ≥ 0x5: illegal; `err_cnt`+1; no other action.
- `rx_valid` while not IDLE (overrun): byte dropped, `err_cnt`+1.
- `err_cnt` saturates at 15. It is cleared only by `Rst`.
- `last_op` = op[2:0] of the most recent accepted legal command.
- States: IDLE, CLR, ADD, GAP, TX_START, TX_HOLD, TX_WAIT.
  - IDLE→CLR (op 1), →ADD (op 2), →TX_START (op 3/4); NOP and illegal commands stay in IDLE.
  - CLR→IDLE.
  - ADD→GAP, or →IDLE after the final pulse.
  - GAP→ADD after `ADD_GAP`−1 cycles in GAP. For `ADD_GAP`=1, ADD repeats back-to-back.
  - TX_START→TX_HOLD→TX_WAIT.
  - TX_WAIT→TX_START (`sel`+1) when `tx_busy`=0 and bytes remain; →IDLE when `tx_busy`=0 and the last byte is done.
- `sel` holds its value from TX_START until leaving TX_WAIT, and returns to 0 on return to IDLE.
- `tx_data` is combinational: `mux_data` in READ mode, latched status in STATUS mode.
- The burst counter is 4 bits, so n=15 gives exactly 16 pulses or 16 bytes, with no wrap.

## Timing
- Reset values: `tx_start`=0, `sel`=0, `acc_add`=0, `acc_clear`=0, `busy`=0, `status`=0x00, state IDLE, all counters 0.
- `Rst` mid-operation aborts immediately. No further strobes are issued.
- Command accepted at cycle t. First action occurs at cycle t+1:
  - `acc_clear` (CLR), or
  - first `acc_add` (ADD), or
  - `tx_start` (TX_START).
- ACC n: pulses at t+1+k·`ADD_GAP`, k=0..n. `busy` falls at t+2+n·`ADD_GAP`.
- TX_HOLD ignores `tx_busy` for one cycle to cover the UART's one-cycle busy rise latency.
- Next `tx_start` occurs no earlier than the cycle after `tx_busy` is sampled 0 in TX_WAIT. Minimum byte-to-byte spacing is 3 cycles.
- `rx_valid` in the same cycle the FSM returns to IDLE is counted as overrun. Acceptance requires IDLE in the current state.
- Strobes are one cycle wide and never overlap. At most one of `acc_add`, `acc_clear`, `tx_start` is high per cycle.

## Test plan
- Reset, then CLEAR: `Rst` high 2 cycles, rx 0x10 at t → `acc_clear`=1 only at t+1; `status`=0x10 after; `busy` low by t+2.
- ACC burst: `ADD_GAP`=4, rx 0x22 at t → `acc_add` at t+1, t+5, t+9 only; `busy` high from t+1 through t+9.
- READ with stub UART (busy 10 cycles, asserted 1 cycle after `tx_start`), `mux_data`=0xA0+`sel`, rx 0x33 → four `tx_start` pulses with `tx_data` 0xA0, 0xA1, 0xA2, 0xA3; `sel` stable while `tx_busy`=1; IDLE afterward with `sel`=0.
- Errors: rx 0x7F, then 0x3F followed by 0x00 mid-READ → `err_cnt`=2; the 0x00 is dropped; all 16 bytes are still sent. Seventeen illegal bytes → `err_cnt` saturates at 0xF.
- STATUS: after the two errors above, rx 0x40 → one byte transmitted = 0xB2 (busy=1, last_op=3, err=2).
- Reset mid-READ: assert `Rst` during TX_WAIT of byte 5 → next cycle all outputs at reset values; no further `tx_start`; a new command is accepted normally afterward.
